mux_n1_stream: RTL and testbench
================================

// Module: mux_n1_stream
// PURPOSE
//  Parametrised N:1, W-bit streaming multiplexer with a valid/ready handshake on every port
//  and one registered output stage. Generalises the 2:1 bit mux to N channels of W bits.
//  Two channel-selection modes: external select (S) or internal round-robin arbitration.
//  Sits between several producer streams and one shared consumer: bus merge or shared datapath.
// PARAMETERS
//  N     4  number of input channels, >=2
//  W     8  data width per channel, >=1
//  SW    2  select/channel-index width, $clog2(N), >=1
//  MODE  0  0 = external select via S; 1 = round-robin arbitration (S ignored)
// PORTS
//  CLK    in   1    clock; all logic on the rising edge
//  RST    in   1    synchronous reset, active-high
//  IN_D   in   N*W  channel data; channel k = IN_D[k*W +: W]
//  IN_V   in   N    per-channel valid
//  IN_R   out  N    per-channel ready; combinational, at most one bit set
//  S      in   SW   channel select, MODE=0 only
//  Y      out  W    registered output data
//  Y_CH   out  SW   index of the channel that produced Y
//  Y_V    out  1    output valid
//  Y_R    in   1    output ready from consumer
// BEHAVIOUR
//  - Reset (RST=1 at an edge): Y=0, Y_CH=0, Y_V=0, rr pointer=N-1. IN_R=0 while RST=1.
//  - Transfer definition: input transfer on channel k = IN_V[k]&IN_R[k] at the edge.
//    Output transfer = Y_V&Y_R at the edge.
//  - Load enable: LD = ~Y_V | Y_R (output register empty, or being drained this cycle).
//  - Grant g (combinational):
//    - MODE=0: g=S when S<N and IN_V[S]=1; otherwise no grant. S>=N never grants.
//    - MODE=1: first k with IN_V[k]=1, searching ptr+1, ptr+2, ... mod N.
//      Wraps from N-1 to 0. No valid channel means no grant.
//  - IN_R[k] = LD & grant & (k==g). IN_R never depends on IN_D.
//  - On an edge with LD=1:
//    - grant present: Y<=IN_D[g], Y_CH<=g, Y_V<=1.
//    - no grant: Y_V<=0; Y and Y_CH hold.
//  - On an edge with LD=0: Y, Y_CH and Y_V hold (backpressure). Y is stable while Y_V&~Y_R.
//  - rr pointer: ptr<=g on every input transfer (MODE=1); otherwise holds.
//    Fairness: with all channels valid, grants run 0,1,...,N-1,0,...
//  - Latency: input transfer at edge t -> Y_V=1 with that data after edge t.
//    Throughput: 1 beat/cycle with Y_R held at 1.
//  - Simultaneous output drain and new load in the same cycle is allowed (LD=1 via Y_R).
//    No bubble between beats.
//  - RST mid-stream: any beat held in the output register is discarded, ptr returns to N-1,
//    and no input transfer occurs in the reset cycle.
//  - Handshake rule on inputs: once IN_V is raised it is not dropped before the transfer.
//    The MODE=0 S input may change on any cycle; it only affects the current grant.
// CONFIGURATION
//  - MUX_N1_BEATCNT_EN defined:
//    - Adds output port BEAT_CNT, out, 16 bits: count of output transfers since reset.
//    - Reset value 0. Increments by 1 on each Y_V&Y_R. Wraps 16'hFFFF -> 0.
//  - MUX_N1_BEATCNT_EN undefined: the port and the counter do not exist.
//    All other behaviour is identical.
// TESTING (N=4, W=8)
//  - Reset: RST=1 for 2 cycles with all IN_V=1 -> IN_R=0, Y_V=0, Y=0, Y_CH=0;
//    after release, first MODE=1 grant is channel 0.
//  - MODE=0, S=2, IN_D[ch2]=8'hA5, IN_V=4'b0100, Y_R=1 -> IN_R=4'b0100;
//    next cycle Y=8'hA5, Y_CH=2, Y_V=1.
//  - MODE=0, S=1, IN_V=4'b1101 -> IN_R=0 and Y_V drops to 0 after the current beat drains.
//  - MODE=1, IN_V=4'b1111 held, Y_R=1, data = channel index -> Y_CH sequence 0,1,2,3,0,1
//    on consecutive cycles with no bubbles.
//  - MODE=1, Y_V=1 with Y=8'h3C and Y_R=0 for 3 cycles -> Y holds 8'h3C, IN_R=0, ptr unchanged;
//    Y_R=1 -> next beat loads in the same cycle.
//  - BEATCNT_EN: 70000 output transfers from reset -> BEAT_CNT = 70000-65536 = 4464.
//    RST mid-run -> 0.

Source files
------------

// File: rtl/mux_n1_stream.sv
// N:1 W-bit streaming multiplexer, valid/ready on every port, one registered output stage.
// Optional 16-bit output beat counter enabled by defining MUX_N1_BEATCNT_EN.
module mux_n1_stream #(
   parameter int unsigned N    = 4,
   parameter int unsigned W    = 8,
   parameter int unsigned SW   = 2,
   parameter int unsigned MODE = 0
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic [N*W-1:0] IN_D,
   input  logic [N-1:0]   IN_V,
   output logic [N-1:0]   IN_R,
   input  logic [SW-1:0]  S,
   output logic [W-1:0]   Y,
   output logic [SW-1:0]  Y_CH,
   output logic           Y_V,
   input  logic           Y_R
`ifdef MUX_N1_BEATCNT_EN
   ,
   output logic [15:0]    BEAT_CNT
`endif
);

   logic [W-1:0]  y_q;
   logic [SW-1:0] ch_q;
   logic          v_q;
   logic [SW-1:0] ptr_q;

   logic          ld;
   logic          grant;
   logic [SW-1:0] g;
   logic [SW-1:0] idx;
   logic [N-1:0]  in_r;

   // Output register may accept a new beat when empty or being drained this cycle.
   assign ld = ~v_q | Y_R;

   always_comb begin
      grant = 1'b0;
      g     = '0;
      idx   = '0;
      if (MODE == 0) begin
         if ((32'(S) < N) && IN_V[S]) begin
            grant = 1'b1;
            g     = S;
         end
      end else begin
         // Rotating search starting just after the last granted channel.
         for (int unsigned i = 1; i <= N; i++) begin
            idx = SW'((32'(ptr_q) + i) % N);
            if (!grant && IN_V[idx]) begin
               grant = 1'b1;
               g     = idx;
            end
         end
      end
   end

   always_comb begin
      in_r = '0;
      if (!RST && ld && grant) begin
         in_r[g] = 1'b1;
      end
   end

   assign IN_R = in_r;

   always_ff @(posedge CLK) begin
      if (RST) begin
         y_q   <= '0;
         ch_q  <= '0;
         v_q   <= 1'b0;
         ptr_q <= SW'(N - 1);
      end else begin
         if (ld) begin
            if (grant) begin
               y_q  <= IN_D[g*W +: W];
               ch_q <= g;
               v_q  <= 1'b1;
            end else begin
               v_q  <= 1'b0;
            end
         end
         if ((MODE == 1) && ld && grant) begin
            ptr_q <= g;
         end
      end
   end

   assign Y    = y_q;
   assign Y_CH = ch_q;
   assign Y_V  = v_q;

`ifdef MUX_N1_BEATCNT_EN
   logic [15:0] beat_cnt_q;

   // Free-running wrap at 16 bits.
   always_ff @(posedge CLK) begin
      if (RST) begin
         beat_cnt_q <= '0;
      end else if (v_q && Y_R) begin
         beat_cnt_q <= beat_cnt_q + 16'd1;
      end
   end

   assign BEAT_CNT = beat_cnt_q;
`endif

endmodule

// File: tb/tb_mux_n1_stream.sv
// Self-checking bench for mux_n1_stream: one external-select and one round-robin instance,
// checked each cycle against a transaction-level model; honours MUX_N1_BEATCNT_EN.
module tb_mux_n1_stream;

   logic        clk;
   logic        rst;
   logic [31:0] d  [2];
   logic [3:0]  v  [2];
   logic [3:0]  r  [2];
   logic [1:0]  s  [2];
   logic [7:0]  y  [2];
   logic [1:0]  ch [2];
   logic        yv [2];
   logic        yr [2];
`ifdef MUX_N1_BEATCNT_EN
   logic [15:0] cnt [2];
`endif

   int vectors;
   int miscompares;

   mux_n1_stream #(.N(4), .W(8), .SW(2), .MODE(0)) u_dut0 (
      .CLK(clk), .RST(rst), .IN_D(d[0]), .IN_V(v[0]), .IN_R(r[0]), .S(s[0]),
      .Y(y[0]), .Y_CH(ch[0]), .Y_V(yv[0]), .Y_R(yr[0])
`ifdef MUX_N1_BEATCNT_EN
      , .BEAT_CNT(cnt[0])
`endif
   );

   mux_n1_stream #(.N(4), .W(8), .SW(2), .MODE(1)) u_dut1 (
      .CLK(clk), .RST(rst), .IN_D(d[1]), .IN_V(v[1]), .IN_R(r[1]), .S(s[1]),
      .Y(y[1]), .Y_CH(ch[1]), .Y_V(yv[1]), .Y_R(yr[1])
`ifdef MUX_N1_BEATCNT_EN
      , .BEAT_CNT(cnt[1])
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Channel the rules pick: -1 when nothing may be granted.
   function automatic int model_grant(input int mode, input logic [3:0] vv, input int sel,
                                      input int ptr);
      if (mode == 0) return (sel < 4 && vv[sel]) ? sel : -1;
      for (int j = 1; j <= 4; j++) begin
         if (vv[(ptr + j) % 4]) return (ptr + j) % 4;
      end
      return -1;
   endfunction

   // Model: contents of the output slot, rr pointer, beat count.
   logic       armed;
   logic       mv [2], nv [2];
   logic [7:0] md [2], nd [2];
   logic [1:0] mc [2], nc [2];
   int         mp [2], np [2];
`ifdef MUX_N1_BEATCNT_EN
   logic [15:0] mcnt [2], ncnt [2];
`endif

   initial armed = 1'b0;

   always @(negedge clk) begin
      if (armed) begin
         for (int m = 0; m < 2; m++) begin
            bit  can_take;
            int  gm;
            logic [3:0] er;
            can_take = !mv[m] || yr[m];
            gm = model_grant(m, v[m], int'(s[m]), mp[m]);
            er = (!rst && can_take && gm >= 0) ? (4'b0001 << gm) : 4'b0000;
            check($sformatf("in_r%0d", m), 32'(r[m]), 32'(er));
            check($sformatf("y_v%0d", m), 32'(yv[m]), 32'(mv[m]));
            if (mv[m]) begin
               check($sformatf("y%0d", m), 32'(y[m]), 32'(md[m]));
               check($sformatf("y_ch%0d", m), 32'(ch[m]), 32'(mc[m]));
            end
`ifdef MUX_N1_BEATCNT_EN
            check($sformatf("beat_cnt%0d", m), 32'(cnt[m]), 32'(mcnt[m]));
            ncnt[m] = mcnt[m] + ((mv[m] && yr[m]) ? 16'd1 : 16'd0);
`endif
            nv[m] = mv[m];
            nd[m] = md[m];
            nc[m] = mc[m];
            np[m] = mp[m];
            if (can_take) begin
               if (gm >= 0) begin
                  nv[m] = 1'b1;
                  nd[m] = d[m][gm*8 +: 8];
                  nc[m] = 2'(gm);
                  if (m == 1) np[m] = gm;
               end else begin
                  nv[m] = 1'b0;
               end
            end
         end
      end
   end

   always @(posedge clk) begin
      for (int m = 0; m < 2; m++) begin
         if (rst) begin
            mv[m] <= 1'b0;
            md[m] <= 8'h00;
            mc[m] <= 2'd0;
            mp[m] <= 3;
`ifdef MUX_N1_BEATCNT_EN
            mcnt[m] <= 16'd0;
`endif
         end else if (armed) begin
            mv[m] <= nv[m];
            md[m] <= nd[m];
            mc[m] <= nc[m];
            mp[m] <= np[m];
`ifdef MUX_N1_BEATCNT_EN
            mcnt[m] <= ncnt[m];
`endif
         end
      end
      if (rst) armed <= 1'b1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] hold [2];

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst = 1'b1;
      for (int m = 0; m < 2; m++) begin
         d[m]  = 32'h0;
         v[m]  = 4'hF;
         s[m]  = 2'd0;
         yr[m] = 1'b1;
      end

      // Reset held two cycles with every channel requesting.
      step();
      step();
      for (int m = 0; m < 2; m++) begin
         check("rst_in_r", 32'(r[m]), 32'h0);
         check("rst_y_v", 32'(yv[m]), 32'h0);
         check("rst_y", 32'(y[m]), 32'h0);
         check("rst_y_ch", 32'(ch[m]), 32'h0);
      end

      rst  = 1'b0;
      d[1] = 32'h0302_0100;
      v[1] = 4'hF;
      d[0] = 32'h00A5_0000;
      v[0] = 4'b0100;
      s[0] = 2'd2;
      #1;
      check("rr_first_grant", 32'(r[1]), 32'h1);
      check("sel2_in_r", 32'(r[0]), 32'h4);

      step();
      check("sel2_y", 32'(y[0]), 32'hA5);
      check("sel2_y_ch", 32'(ch[0]), 32'h2);
      check("sel2_y_v", 32'(yv[0]), 32'h1);
      check("rr_seq_y_ch", 32'(ch[1]), 32'h0);
      check("rr_seq_y_v", 32'(yv[1]), 32'h1);
      s[0] = 2'd1;
      v[0] = 4'b1101;
      #1;
      check("sel_idle_in_r", 32'(r[0]), 32'h0);

      for (int i = 1; i <= 5; i++) begin
         step();
         if (i == 1) check("sel_idle_y_v", 32'(yv[0]), 32'h0);
         check("rr_seq_y_ch", 32'(ch[1]), 32'(i % 4));
         check("rr_seq_y", 32'(y[1]), 32'(i % 4));
         check("rr_seq_y_v", 32'(yv[1]), 32'h1);
      end

      // Backpressure: hold a 3C beat for three cycles, then drain and reload together.
      d[1] = 32'h3C3C_3C3C;
      step();
      check("bp_load_y", 32'(y[1]), 32'h3C);
      check("bp_load_y_ch", 32'(ch[1]), 32'h2);
      yr[1] = 1'b0;
      #1;
      check("bp_in_r", 32'(r[1]), 32'h0);
      repeat (3) begin
         step();
         check("bp_hold_y", 32'(y[1]), 32'h3C);
         check("bp_hold_y_v", 32'(yv[1]), 32'h1);
         check("bp_hold_y_ch", 32'(ch[1]), 32'h2);
         check("bp_hold_in_r", 32'(r[1]), 32'h0);
      end
      yr[1] = 1'b1;
      #1;
      check("bp_release_in_r", 32'(r[1]), 32'h8);
      step();
      check("bp_release_y_ch", 32'(ch[1]), 32'h3);
      check("bp_release_y_v", 32'(yv[1]), 32'h1);

      // Random traffic; a raised valid stays up (with its data) until it transfers.
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         for (int m = 0; m < 2; m++) hold[m] = v[m] & ~r[m];
         @(posedge clk);
         #1;
         rst = ($urandom_range(0, 199) == 0);
         for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 4; k++) begin
               if (!hold[m][k]) begin
                  v[m][k]        = ($urandom_range(0, 2) != 0);
                  d[m][k*8 +: 8] = 8'($urandom);
               end
            end
            yr[m] = ($urandom_range(0, 3) != 0);
            s[m]  = 2'($urandom);
         end
      end

`ifdef MUX_N1_BEATCNT_EN
      rst = 1'b1;
      step();
      rst   = 1'b0;
      v[1]  = 4'hF;
      yr[1] = 1'b1;
      repeat (70001) step();
      check("beat_cnt_wrap", 32'(cnt[1]), 32'd4464);
      rst = 1'b1;
      step();
      check("beat_cnt_rst", 32'(cnt[1]), 32'd0);
`endif

      rst = 1'b0;
      repeat (3) step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
